// File: rtl/cpu_player_ctrl_if.sv
// Player-2 controller bus: game-state/LFSR inputs towards the controller and
// the emulated button plus status back out.
//   enable       game active
//   round_over   1-cycle pulse, a point was scored
//   difficulty   press threshold (press when lfsr_val < difficulty)
//   lfsr_val     current LFSR output
//   press        emulated button, active high
//   lfsr_sample  1-cycle pulse, a sample was taken on the previous cycle
//   busy         high while pressing or cooling down
//   press_count  presses issued this round, saturating
interface cpu_player_ctrl_if #(
  parameter int unsigned W = 10
);
  logic         enable;
  logic         round_over;
  logic [W-1:0] difficulty;
  logic [W-1:0] lfsr_val;
  logic         press;
  logic         lfsr_sample;
  logic         busy;
  logic [7:0]   press_count;

  // Game logic / LFSR side
  modport master (
    output enable, round_over, difficulty, lfsr_val,
    input  press, lfsr_sample, busy, press_count
  );

  // Controller side
  modport slave (
    input  enable, round_over, difficulty, lfsr_val,
    output press, lfsr_sample, busy, press_count
  );
endinterface

// File: rtl/cpu_player_ctrl.sv
// Computer-opponent controller for tug-of-war. Once per decision tick the
// LFSR value is compared against the difficulty threshold; a hit produces a
// fixed-length press followed by an equally long release gap so the
// downstream edge detector always sees a clean press.
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    cpu_player_ctrl_if.slave (enable, round_over, difficulty,
//          lfsr_val in; press, lfsr_sample, busy, press_count out)
module cpu_player_ctrl #(
  parameter int unsigned W            = 10,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned PRESS_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  cpu_player_ctrl_if.slave bus
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PRESS = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [PW-1:0] ph, ph_d;
  logic [7:0]    count_q, count_d;
  logic          press_q, busy_q, sample_q;
  logic          tick_c;
  logic [W-1:0]  difficulty_c, lfsr_c;

  assign difficulty_c = bus.difficulty;
  assign lfsr_c       = bus.lfsr_val;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ph       <= '0;
      count_q  <= '0;
      press_q  <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ph       <= ph_d;
      count_q  <= count_d;
      // Outputs decode the next state so they change on the same edge as it
      press_q  <= (state_d == PRESS);
      busy_q   <= (state_d == PRESS) || (state_d == COOL);
      sample_q <= tick_c;
    end
  end

  // Next state; round_over beats !enable beats normal sequencing
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ph_d    = ph;
    count_d = count_q;
    tick_c  = 1'b0;

    if (bus.round_over) begin
      state_d = IDLE;
      cnt_d   = '0;
      ph_d    = '0;
      count_d = '0;
    end else if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      ph_d    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = '0;
          ph_d    = '0;
        end
        WAIT: begin
          if (cnt == TICK_LAST) begin
            tick_c = 1'b1;
            cnt_d  = '0;
            if (lfsr_c < difficulty_c) begin
              state_d = PRESS;
              ph_d    = '0;
              if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        PRESS: begin
          cnt_d = '0;
          if (ph == PH_LAST) begin
            state_d = COOL;
            ph_d    = '0;
          end else begin
            ph_d = ph + PW'(1);
          end
        end
        COOL: begin
          cnt_d = '0;
          if (ph == PH_LAST) begin
            state_d = WAIT;
            ph_d    = '0;
          end else begin
            ph_d = ph + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          ph_d    = '0;
        end
      endcase
    end
  end

  assign bus.press       = press_q;
  assign bus.busy        = busy_q;
  assign bus.lfsr_sample = sample_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_cpu_player_ctrl.sv
// Directed bench for cpu_player_ctrl with TICK_DIV=4, PRESS_CYCLES=2.
// Edge numbering: E1 is the first rising edge that samples enable=1 from
// IDLE; the tick lands in the cycle after E4, so press rises on E5 and the
// pattern repeats every 8 edges (4 WAIT, 2 PRESS, 2 COOL).
module tb_cpu_player_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cpu_player_ctrl_if #(.W(10)) bus ();

  cpu_player_ctrl #(
    .W(10),
    .TICK_DIV(4),
    .PRESS_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick_edge;
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE with press_count cleared
  task automatic restart;
    bus.enable     = 1'b0;
    bus.round_over = 1'b1;
    tick_edge();
    bus.round_over = 1'b0;
  endtask

  task automatic setup_hit;
    bus.difficulty = 10'h3FF;
    bus.lfsr_val   = 10'h010;
    bus.enable     = 1'b1;
  endtask

  // Expected always-hit sequence starting from IDLE with press_count=0
  task automatic check_seq(input string tag, input int n);
    logic e_press, e_busy, e_sample;
    int   e_count, q;
    for (int k = 1; k <= n; k++) begin
      tick_edge();
      e_press = 1'b0; e_busy = 1'b0; e_sample = 1'b0; e_count = 0;
      if (k >= 5) begin
        q        = (k - 5) % 8;
        e_press  = (q < 2);
        e_busy   = (q < 4);
        e_sample = (q == 0);
        e_count  = (k - 5) / 8 + 1;
      end
      n_checks += 4;
      if (bus.press !== e_press) begin
        n_fail++; $display("FAIL %s press E%0d got %b want %b", tag, k, bus.press, e_press);
      end
      if (bus.busy !== e_busy) begin
        n_fail++; $display("FAIL %s busy E%0d got %b want %b", tag, k, bus.busy, e_busy);
      end
      if (bus.lfsr_sample !== e_sample) begin
        n_fail++; $display("FAIL %s lfsr_sample E%0d got %b want %b", tag, k, bus.lfsr_sample, e_sample);
      end
      if (bus.press_count !== 8'(e_count)) begin
        n_fail++; $display("FAIL %s press_count E%0d got %0d want %0d", tag, k, bus.press_count, e_count);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] e_count);
    n_checks += 4;
    if (bus.press !== 1'b0) begin
      n_fail++; $display("FAIL %s press got %b want 0", tag, bus.press);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy got %b want 0", tag, bus.busy);
    end
    if (bus.lfsr_sample !== 1'b0) begin
      n_fail++; $display("FAIL %s lfsr_sample got %b want 0", tag, bus.lfsr_sample);
    end
    if (bus.press_count !== e_count) begin
      n_fail++; $display("FAIL %s press_count got %0d want %0d", tag, bus.press_count, e_count);
    end
  endtask

  task automatic test_reset;
    bus.enable     = 1'b0;
    bus.round_over = 1'b0;
    bus.difficulty = '0;
    bus.lfsr_val   = '0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_async", 8'd0);
    repeat (3) tick_edge();
    check_idle_outputs("reset_held", 8'd0);
    reset = 1'b1;
    tick_edge();
    check_idle_outputs("reset_release", 8'd0);
  endtask

  task automatic test_press_seq;
    restart();
    setup_hit();
    check_seq("press_seq", 24);
  endtask

  task automatic test_difficulty_zero;
    logic e_sample;
    restart();
    bus.difficulty = 10'h000;
    bus.lfsr_val   = 10'h010;
    bus.enable     = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick_edge();
      e_sample = (k >= 5) && ((k - 5) % 4 == 0);
      n_checks += 3;
      if (bus.press !== 1'b0) begin
        n_fail++; $display("FAIL diff0 press E%0d got %b want 0", k, bus.press);
      end
      if (bus.lfsr_sample !== e_sample) begin
        n_fail++; $display("FAIL diff0 lfsr_sample E%0d got %b want %b", k, bus.lfsr_sample, e_sample);
      end
      if (bus.press_count !== 8'd0) begin
        n_fail++; $display("FAIL diff0 press_count E%0d got %0d want 0", k, bus.press_count);
      end
    end
  endtask

  task automatic test_strict_compare;
    restart();
    bus.difficulty = 10'h200;
    bus.lfsr_val   = 10'h200;
    bus.enable     = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      n_checks += 2;
      if (bus.press !== 1'b0) begin
        n_fail++; $display("FAIL strict press E%0d got %b want 0", k, bus.press);
      end
      if (bus.lfsr_sample !== (k == 5)) begin
        n_fail++; $display("FAIL strict lfsr_sample E%0d got %b want %b", k, bus.lfsr_sample, (k == 5));
      end
    end
    bus.lfsr_val = 10'h1FF;
    tick_edge();
    n_checks += 3;
    if (bus.press !== 1'b1) begin
      n_fail++; $display("FAIL strict_1ff press got %b want 1", bus.press);
    end
    if (bus.lfsr_sample !== 1'b1) begin
      n_fail++; $display("FAIL strict_1ff lfsr_sample got %b want 1", bus.lfsr_sample);
    end
    if (bus.press_count !== 8'd1) begin
      n_fail++; $display("FAIL strict_1ff press_count got %0d want 1", bus.press_count);
    end
  endtask

  task automatic test_lockup_value;
    restart();
    bus.difficulty = 10'h3FF;
    bus.lfsr_val   = 10'h3FF;
    bus.enable     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_edge();
      n_checks += 2;
      if (bus.press !== 1'b0) begin
        n_fail++; $display("FAIL lockup press E%0d got %b want 0", k, bus.press);
      end
      if (bus.lfsr_sample !== (k == 5 || k == 9)) begin
        n_fail++; $display("FAIL lockup lfsr_sample E%0d got %b want %b", k, bus.lfsr_sample, (k == 5 || k == 9));
      end
    end
  endtask

  task automatic test_round_over_press;
    restart();
    setup_hit();
    repeat (5) tick_edge();
    n_checks++;
    if (bus.press !== 1'b1) begin
      n_fail++; $display("FAIL ro_press pre press got %b want 1", bus.press);
    end
    bus.round_over = 1'b1;
    tick_edge();
    bus.round_over = 1'b0;
    check_idle_outputs("ro_press", 8'd0);
    // IDLE, then WAIT from count 0: press returns on the 5th edge
    for (int j = 1; j <= 5; j++) begin
      tick_edge();
      n_checks++;
      if (bus.press !== (j == 5)) begin
        n_fail++; $display("FAIL ro_press restart press J%0d got %b want %b", j, bus.press, (j == 5));
      end
    end
    n_checks++;
    if (bus.press_count !== 8'd1) begin
      n_fail++; $display("FAIL ro_press restart press_count got %0d want 1", bus.press_count);
    end
  endtask

  task automatic test_round_over_tick;
    restart();
    setup_hit();
    repeat (4) tick_edge();
    bus.round_over = 1'b1;
    tick_edge();
    bus.round_over = 1'b0;
    check_idle_outputs("ro_tick", 8'd0);
  endtask

  task automatic test_enable_drop;
    restart();
    setup_hit();
    repeat (5) tick_edge();
    n_checks += 2;
    if (bus.press !== 1'b1) begin
      n_fail++; $display("FAIL en_drop pre press got %b want 1", bus.press);
    end
    if (bus.press_count !== 8'd1) begin
      n_fail++; $display("FAIL en_drop pre press_count got %0d want 1", bus.press_count);
    end
    bus.enable = 1'b0;
    tick_edge();
    check_idle_outputs("en_drop", 8'd1);
  endtask

  task automatic test_midpress_change;
    restart();
    setup_hit();
    repeat (5) tick_edge();
    bus.difficulty = 10'h000;
    bus.lfsr_val   = 10'h3FF;
    for (int k = 6; k <= 13; k++) begin
      tick_edge();
      n_checks += 3;
      if (bus.press !== (k == 6)) begin
        n_fail++; $display("FAIL midchg press E%0d got %b want %b", k, bus.press, (k == 6));
      end
      if (bus.lfsr_sample !== (k == 13)) begin
        n_fail++; $display("FAIL midchg lfsr_sample E%0d got %b want %b", k, bus.lfsr_sample, (k == 13));
      end
      if (bus.press_count !== 8'd1) begin
        n_fail++; $display("FAIL midchg press_count E%0d got %0d want 1", k, bus.press_count);
      end
    end
  endtask

  task automatic test_reset_midpress;
    restart();
    setup_hit();
    repeat (5) tick_edge();
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid", 8'd0);
    repeat (2) tick_edge();
    reset = 1'b1;
    check_seq("reset_restart", 16);
  endtask

  task automatic test_saturation;
    restart();
    setup_hit();
    for (int k = 1; k <= 2053; k++) begin
      tick_edge();
      if (k == 2029 || k == 2037 || k == 2053) begin
        n_checks++;
        if (bus.press_count !== ((k == 2029) ? 8'd254 : 8'd255)) begin
          n_fail++; $display("FAIL saturate press_count E%0d got %0d want %0d", k, bus.press_count, (k == 2029) ? 254 : 255);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_press_seq();
    test_difficulty_zero();
    test_strict_compare();
    test_lockup_value();
    test_round_over_press();
    test_round_over_tick();
    test_enable_drop();
    test_midpress_change();
    test_reset_midpress();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
